// File: rtl/disp_value_sel_flash.sv
// Registered 4-digit display value selector with compare glyph, state letter
// and a divided flash that blanks digits 0/1 in selected states.
module disp_value_sel_flash #(
  parameter int           DIGIT_W    = 4,
  parameter int           STATE_W    = 4,
  parameter int           FLASH_DIV  = 25000000,
  parameter logic [7:0]   FLASH_MASK = 8'hF0,
  parameter int           BLANK_CODE = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STATE_W-1:0]     state,
  input  logic [2*DIGIT_W-1:0]   x_val,
  input  logic [2*DIGIT_W-1:0]   y_val,
  input  logic [2*DIGIT_W-1:0]   s_lo,
  input  logic [2*DIGIT_W-1:0]   s_hi,
  output logic [DIGIT_W-1:0]     final1,
  output logic [DIGIT_W-1:0]     final2,
  output logic [DIGIT_W-1:0]     final3,
  output logic [DIGIT_W-1:0]     final4,
  output logic                   flash_on
);

  localparam int CW = $clog2(FLASH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(FLASH_DIV - 1);
  localparam logic [DIGIT_W-1:0] BLANK = DIGIT_W'(BLANK_CODE);
  localparam logic [DIGIT_W-1:0] LT_GLYPH = DIGIT_W'(14);
  localparam logic [DIGIT_W-1:0] GE_GLYPH = DIGIT_W'(15);
  localparam logic [DIGIT_W-1:0] LETTER0 = DIGIT_W'(10);

  logic [2*DIGIT_W-1:0] pair_q, pair_d;
  logic [DIGIT_W-1:0]   final1_q, final1_d;
  logic [DIGIT_W-1:0]   final2_q, final2_d;
  logic [DIGIT_W-1:0]   final3_q, final3_d;
  logic [DIGIT_W-1:0]   final4_q, final4_d;
  logic                 flash_q, flash_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic [STATE_W-1:0]   prev_q, prev_d;
  logic                 low_state;

  assign low_state = (state < STATE_W'(8));

  always_comb begin
    pair_d = pair_q;
    if (state == STATE_W'(0) || state == STATE_W'(6) ||
        state == STATE_W'(7)) begin
      pair_d = x_val;
    end else if (state == STATE_W'(1) || state == STATE_W'(4) ||
                 state == STATE_W'(5)) begin
      pair_d = y_val;
    end else if (state == STATE_W'(2)) begin
      pair_d = s_lo;
    end else if (state == STATE_W'(3)) begin
      pair_d = s_hi;
    end
  end

  always_comb begin
    final3_d = (x_val < y_val) ? LT_GLYPH : GE_GLYPH;
    final4_d = final4_q;
    if (state < STATE_W'(4)) begin
      final4_d = LETTER0 + DIGIT_W'(state[1:0]);
    end
  end

  // A state change restarts the flash with the visible phase first.
  always_comb begin
    flash_d = low_state ? FLASH_MASK[state[2:0]] : 1'b0;
    cnt_d   = '0;
    phase_d = 1'b0;
    prev_d  = state;
    if (flash_d && (state == prev_q)) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end
  end

  always_comb begin
    final1_d = pair_d[DIGIT_W-1:0];
    final2_d = pair_d[2*DIGIT_W-1:DIGIT_W];
    if (flash_d && phase_d) begin
      final1_d = BLANK;
      final2_d = BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q   <= '0;
      final1_q <= '0;
      final2_q <= '0;
      final3_q <= GE_GLYPH;
      final4_q <= LETTER0;
      flash_q  <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      prev_q   <= '0;
    end else begin
      pair_q   <= pair_d;
      final1_q <= final1_d;
      final2_q <= final2_d;
      final3_q <= final3_d;
      final4_q <= final4_d;
      flash_q  <= flash_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      prev_q   <= prev_d;
    end
  end

  assign final1   = final1_q;
  assign final2   = final2_q;
  assign final3   = final3_q;
  assign final4   = final4_q;
  assign flash_on = flash_q;

endmodule
